onehot_seq_encoder: RTL and testbench

//   Sequential multi-hot-to-binary encoder: the encode side of the 3x8 decoder.

---
 rtl/onehot_seq_encoder_if.sv | 37 +++
 rtl/onehot_seq_encoder.sv | 80 ++++++++
 tb/tb_onehot_seq_encoder.sv | 138 +++++++++++++
 3 files changed

// File: rtl/onehot_seq_encoder_if.sv
// Handshake bundle for the sequential multi-hot-to-binary encoder.
// The slave modport is the encoder's view; the master modport drives requests.
interface onehot_seq_encoder_if #(
    parameter int N = 8,
    parameter int W = $clog2(N)
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_vec;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_code;
    logic         out_last;
    logic         empty_err;

    modport master (
        output in_valid,
        output in_vec,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_code,
        input  out_last,
        input  empty_err
    );

    modport slave (
        input  in_valid,
        input  in_vec,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_code,
        output out_last,
        output empty_err
    );
endinterface

// File: rtl/onehot_seq_encoder.sv
// Sequential multi-hot-to-binary encoder: emits the index of every set bit
// of an accepted vector, lowest first, one code per output handshake.
module onehot_seq_encoder #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    onehot_seq_encoder_if.slave   bus
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t       state;
    logic [N-1:0] pending;
    logic [N-1:0] pend_clr;

    function automatic logic [W-1:0] low_idx(input logic [N-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) r = W'(i);
        end
        return r;
    endfunction

    function automatic logic single(input logic [N-1:0] v);
        return (v != '0) && ((v & (v - N'(1))) == '0);
    endfunction

    // Dropping the lowest set bit is exactly the bit being handed out now.
    assign pend_clr = pending & (pending - N'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pending       <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_code  <= '0;
            bus.out_last  <= 1'b0;
            bus.empty_err <= 1'b0;
        end else begin
            bus.empty_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.in_vec != '0) begin
                            state         <= EMIT;
                            pending       <= bus.in_vec;
                            bus.in_ready  <= 1'b0;
                            bus.out_valid <= 1'b1;
                            bus.out_code  <= low_idx(bus.in_vec);
                            bus.out_last  <= single(bus.in_vec);
                        end else begin
                            bus.empty_err <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        pending      <= pend_clr;
                        bus.out_code <= low_idx(pend_clr);
                        bus.out_last <= single(pend_clr);
                        if (bus.out_last) begin
                            state         <= IDLE;
                            bus.in_ready  <= 1'b1;
                            bus.out_valid <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_onehot_seq_encoder.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based model of the indices still owed to the consumer.
module tb_onehot_seq_encoder;

    localparam int N = 8;
    localparam int W = 3;

    logic clk;
    logic rst_n;

    onehot_seq_encoder_if #(.N(N), .W(W)) bus ();

    onehot_seq_encoder #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    int q[$];
    bit exp_err;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic check_outs();
        check("in_ready", 32'(bus.in_ready), 32'(q.size() == 0));
        check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        check("empty_err", 32'(bus.empty_err), 32'(exp_err));
        if (q.size() != 0) begin
            check("out_code", 32'(bus.out_code), 32'(q[0]));
            check("out_last", 32'(bus.out_last), 32'(q.size() == 1));
        end
    endtask

    // Check what the previous edge produced, then drive the next inputs
    // and advance the model across the coming edge.
    task automatic step(input logic iv, input logic [N-1:0] v,
                        input logic ordy);
        @(negedge clk);
        check_outs();
        bus.in_valid  = iv;
        bus.in_vec    = v;
        bus.out_ready = ordy;
        exp_err = 1'b0;
        if (q.size() == 0) begin
            if (iv) begin
                if (v == '0) exp_err = 1'b1;
                for (int i = 0; i < N; i++) if (v[i]) q.push_back(i);
            end
        end else if (ordy) begin
            void'(q.pop_front());
        end
    endtask

    logic [N-1:0] rv;

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_vec    = '0;
        bus.out_ready = 1'b0;
        exp_err       = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_code", 32'(bus.out_code), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_empty_err", 32'(bus.empty_err), 32'd0);
        rst_n = 1'b1;

        // 2,5,7 back to back
        step(1'b1, 8'b1010_0100, 1'b1);
        repeat (4) step(1'b0, 8'h00, 1'b1);
        // full vector, then next accepted once idle
        step(1'b1, 8'hFF, 1'b1);
        repeat (8) step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h80, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        // stall with out_ready low
        step(1'b1, 8'b0001_0010, 1'b0);
        repeat (4) step(1'b0, 8'h00, 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b1);
        // empty vector
        step(1'b1, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        // input ignored while emitting
        step(1'b1, 8'h81, 1'b1);
        step(1'b1, 8'h0F, 1'b1);
        step(1'b1, 8'h0F, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);

        // reset in the middle of F0, after code 4 handshake
        step(1'b1, 8'hF0, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_out_code", 32'(bus.out_code), 32'd0);
        q.delete();
        exp_err = 1'b0;
        #1;
        rst_n = 1'b1;
        repeat (4) step(1'b0, 8'h00, 1'b1);

        // random traffic
        for (int k = 0; k < 600; k++) begin
            case ($urandom_range(0, 3))
                0: rv = '0;
                1: rv = N'(1) << $urandom_range(0, N - 1);
                default: rv = N'($urandom);
            endcase
            step(1'($urandom_range(0, 1)), rv,
                 1'($urandom_range(0, 3) != 0));
        end
        repeat (12) step(1'b0, 8'h00, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
